fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that replaces the single fetch latch between imem and decode with a DEPTH-entry prefetch FIFO. It owns the program counter, drives the imem address, and keeps fetching while decode is stalled until the queue is full. It accepts a redirect (branch, jump or jr target from execute) that flushes all queued instructions in one cycle. It presents the oldest instruction and its PC to decode through a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, instruction and PC width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, PC value after reset

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- address_imem  out  WIDTH  current PC, driven straight from the PC register
- q_imem  in  WIDTH  instruction at address_imem, valid in the same cycle
- redirect  in  1  flush the queue and load redirect_pc
- redirect_pc  in  WIDTH  next fetch address when redirect=1
- deq_ready  in  1  decode accepts the head entry this cycle
- deq_valid  out  1  head entry is valid
- deq_insn  out  WIDTH  head instruction; 0 (nop) when deq_valid=0
- deq_pc  out  WIDTH  PC of the head instruction; 0 when deq_valid=0
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH entries of {pc, insn}. Head and tail pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Dequeue fire: deq = deq_valid & deq_ready & !redirect.
- Enqueue fire: enq = !redirect & (count<DEPTH | deq). On enq, {address_imem, q_imem} is written at tail and PC <= PC+1, modulo 2^WIDTH.
- A full queue with a simultaneous dequeue still enqueues. count stays at DEPTH.
- When enq=0 and no redirect, the PC holds.
- Redirect has priority over every other event:
  - count <= 0 and head = tail = 0.
  - PC <= redirect_pc.
  - deq_valid is forced to 0 in the same cycle, so no handshake completes.
  - The word on q_imem that cycle is discarded.
- count update: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Empty (count=0): deq_valid=0 and deq_insn=deq_pc=0, unless FETCH_BYPASS_EN is defined.
- Reset mid-operation is identical to power-on reset: the queue is emptied and PC = RESET_PC.
- Reset overrides redirect.

## Timing
- Reset values: address_imem=RESET_PC, count=0, deq_valid=0, deq_insn=0, deq_pc=0.
- Fetch-to-decode latency: an instruction fetched in cycle N appears at the head in cycle N+1 at the earliest, when the queue was empty. With bypass it appears in cycle N.
- Redirect latency:
  - redirect in cycle N, so address_imem=redirect_pc in cycle N+1.
  - The target instruction is valid at the head in cycle N+2, or in N+1 with bypass.
- Throughput: one instruction per cycle sustained with deq_ready held high. No bubbles at full or at pointer wrap.
- Stall: with deq_ready=0 the queue fills in DEPTH cycles. After that address_imem freezes and the head output is stable.
- deq_insn and deq_pc are read combinationally from storage at head, plus the bypass mux when enabled. They change only on a clock edge, or with q_imem when bypassing.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count=0 and redirect=0, deq_valid=1, deq_insn=q_imem and deq_pc=address_imem.
  - If deq_ready=1 in that cycle, the entry is consumed directly. It is not written, the PC advances, and count stays 0.
  - If deq_ready=0, the entry is enqueued normally.
  - This gives zero-bubble fetch, matching a single fetch latch.
- FETCH_BYPASS_EN undefined: an empty queue always gives deq_valid=0. Minimum latency is 1 cycle as stated above.

## Test plan
- Reset then stream: RESET_PC=0, deq_ready=1, imem[i]=i+0x100.
  - Without bypass: deq_valid first rises in cycle 1 with insn 0x100, pc 0, then 0x101/pc 1 and so on, one per cycle through 3×DEPTH wraps.
  - With bypass: the same sequence starts in cycle 0.
- Backpressure: deq_ready=0 for 10 cycles with DEPTH=4.
  - count reaches 4, address_imem holds at 4, and the head stays insn 0x100.
  - Then deq_ready=1: insns 0x100–0x107 arrive in order with no gap.
- Full plus dequeue: at count=4, pulse deq_ready for 1 cycle. count stays 4, PC advances by 1, and the head becomes the next instruction.
- Redirect while full: count=4, redirect=1 with redirect_pc=0x40 and deq_ready=1 in the same cycle.
  - No dequeue occurs and count becomes 0.
  - The next cycle shows address_imem=0x40.
  - The head shows pc 0x40 two cycles after the redirect (one with bypass).
- Back-to-back redirects: redirect_pc=0x10 then 0x20 in consecutive cycles. No instruction from 0x10 is ever presented, and the first valid head has pc=0x20.
- Reset mid-stream: assert reset with count=3. After one edge, count=0, deq_valid=0 and address_imem=RESET_PC. Fetch resumes from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
// Owns the PC and drives imem. It keeps fetching while decode stalls, until
// the queue is full. A redirect flushes the queue in one cycle and reloads the PC.
//
// Parameters:
//   WIDTH    - instruction / PC width
//   DEPTH    - queue entries (power of two, >= 2)
//   RESET_PC - PC after reset
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   address_imem        - current PC (register output)
//   q_imem              - instruction at address_imem, same cycle
//   redirect/_pc        - flush queue, next fetch from redirect_pc
//   deq_ready/valid     - decode handshake on the head entry
//   deq_insn/deq_pc     - head entry, zero when deq_valid=0
//   count               - occupied entries
// Optional feature: define FETCH_BYPASS_EN to present q_imem directly when the
// queue is empty (zero-bubble fetch).
module fetch_queue #(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [WIDTH-1:0]           address_imem,
    input  logic [WIDTH-1:0]           q_imem,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_insn,
    output logic [WIDTH-1:0]           deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] insn_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [CW-1:0]    cnt;

    logic empty, full, byp, deq, enq, wr, pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

`ifdef FETCH_BYPASS_EN
    // Empty queue: the word arriving from imem is the head this cycle.
    assign byp = empty & ~redirect & ~reset;
`else
    assign byp = 1'b0;
`endif

    assign deq_valid = ~redirect & (~empty | byp);
    assign deq       = deq_valid & deq_ready;
    // A full queue still accepts when its head leaves in the same cycle.
    assign enq       = ~redirect & (~full | deq);
    // A bypassed word consumed immediately never touches storage.
    assign wr        = enq & ~(byp & deq);
    assign pop       = deq & ~byp;

    assign address_imem = pc_q;
    assign count        = cnt;

    always_comb begin
        deq_insn = '0;
        deq_pc   = '0;
        if (deq_valid) begin
            if (byp) begin
                deq_insn = q_imem;
                deq_pc   = pc_q;
            end else begin
                deq_insn = insn_mem[head];
                deq_pc   = pc_mem[head];
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by cnt alone.
    always_ff @(posedge clock) begin
        if (wr && !reset) begin
            insn_mem[tail] <= q_imem;
            pc_mem[tail]   <= pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (redirect) begin
            pc_q <= redirect_pc;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq) pc_q <= pc_q + WIDTH'(1);
            if (wr)  tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            case ({wr, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, redirect, deq_ready;
    logic [31:0] redirect_pc, address_imem, q_imem, deq_insn, deq_pc;
    logic        deq_valid;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    int hs    = 0;
    int h0;
    logic [63:0] exp_q [$];

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .address_imem(address_imem),
        .q_imem(q_imem), .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_insn(deq_insn),
        .deq_pc(deq_pc), .count(count)
    );

    always #5 clock = ~clock;

    // imem model: word at address a is a + 0x100
    assign q_imem = address_imem + 32'h100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({start + 32'(i), start + 32'(i) + 32'h100});
    endtask

    // Monitor: every completed handshake pops and checks one expectation.
    always @(negedge clock) begin
        if (!reset && deq_valid && deq_ready && !redirect) begin
            hs++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_deq: got pc %h insn %h want none", deq_pc, deq_insn);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({deq_pc, deq_insn} !== e) begin
                    n_bad++;
                    $display("FAIL deq_entry: got pc %h insn %h want pc %h insn %h",
                             deq_pc, deq_insn, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
        step; step;
        @(negedge clock);
        chk("rst_addr", address_imem, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_insn", deq_insn, 32'h0);
        chk("rst_pc", deq_pc, 32'h0);

        // Backpressure from an empty queue: 10 cycles with deq_ready=0.
        step; reset = 1'b0;
        @(negedge clock);
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_valid", 32'(deq_valid), 32'(BYP));
        chk("empty_insn", deq_insn, BYP ? 32'h100 : 32'h0);
        repeat (9) step;
        @(negedge clock);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_addr", address_imem, 32'd4);
        chk("bp_valid", 32'(deq_valid), 32'd1);
        chk("bp_insn", deq_insn, 32'h100);
        chk("bp_pc", deq_pc, 32'h0);

        // Full plus one-cycle dequeue.
        step; deq_ready = 1'b1; push_run(32'h0, 1);
        step; deq_ready = 1'b0;
        @(negedge clock);
        chk("fd_count", 32'(count), 32'd4);
        chk("fd_addr", address_imem, 32'd5);
        chk("fd_pc", deq_pc, 32'd1);
        chk("fd_insn", deq_insn, 32'h101);

        // Drain at full with ready held: no bubbles.
        step; deq_ready = 1'b1; push_run(32'd1, 8); h0 = hs;
        repeat (8) step;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("drain_hs", 32'(hs - h0), 32'd8);
        chk("drain_count", 32'(count), 32'd4);
        chk("drain_addr", address_imem, 32'd13);
        chk("drain_pc", deq_pc, 32'd9);

        // Redirect while full, decode ready in the same cycle.
        step;
        chk("pre_redir_sb", 32'(exp_q.size()), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h40; deq_ready = 1'b1;
        @(negedge clock);
        chk("redir_valid", 32'(deq_valid), 32'd0);
        chk("redir_insn", deq_insn, 32'h0);
        step; redirect = 1'b0;
        @(negedge clock);
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_addr", address_imem, 32'h40);
        chk("redir_n1_valid", 32'(deq_valid), 32'(BYP));
        push_run(32'h40, 8); h0 = hs;
        repeat (BYP ? 8 : 9) step;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("redir_hs", 32'(hs - h0), 32'd8);

        // Back-to-back redirects: nothing from 0x10 may appear.
        step;
        exp_q.delete();
        redirect = 1'b1; redirect_pc = 32'h10; deq_ready = 1'b1;
        step; redirect_pc = 32'h20;
        @(negedge clock);
        chk("b2b_addr1", address_imem, 32'h10);
        chk("b2b_valid", 32'(deq_valid), 32'd0);
        step; redirect = 1'b0; push_run(32'h20, 4); h0 = hs;
        @(negedge clock);
        chk("b2b_addr2", address_imem, 32'h20);
        repeat (BYP ? 4 : 5) step;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("b2b_hs", 32'(hs - h0), 32'd4);

        // Reset mid-stream with three entries queued.
        step;
        exp_q.delete();
        redirect = 1'b1; redirect_pc = 32'h80;
        step; redirect = 1'b0;
        repeat (3) step;
        @(negedge clock);
        chk("mid_count3", 32'(count), 32'd3);
        step; reset = 1'b1;
        step;
        @(negedge clock);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(deq_valid), 32'd0);
        chk("mid_rst_addr", address_imem, 32'h0);
        step; reset = 1'b0; push_run(32'h0, 4); h0 = hs; deq_ready = 1'b1;
        repeat (BYP ? 4 : 5) step;
        deq_ready = 1'b0;
        @(negedge clock);
        chk("resume_hs", 32'(hs - h0), 32'd4);
        chk("resume_count", 32'(count), BYP ? 32'd0 : 32'd1);
        step; step;
        chk("final_sb", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
